// File: rtl/pulse_pair_gen_pkg.sv
// Shared state encoding, default widths and the duration clamp for pulse_pair_gen.
package pulse_pkg;

    localparam int unsigned PULSE_CNT_W = 32;
    localparam int unsigned CLAMP_W     = 64;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        DLY,
        P2,
        BLANK
    } state_t;

    // max(x,1): a programmed zero still yields a one-cycle state
    function automatic logic [CLAMP_W-1:0] dur_clamp(input logic [CLAMP_W-1:0] x);
        return (x == '0) ? CLAMP_W'(1) : x;
    endfunction

endpackage

// File: rtl/pulse_pair_gen_if.sv
// Trigger, configuration and status bundle for pulse_pair_gen.
interface pulse_pair_gen_if
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W = PULSE_CNT_W
);

    logic             trig_in;
    logic [CNT_W-1:0] p1_width;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] p2_width;
    logic             pulse_out;
    logic             block_out;
    logic             busy;
    logic             done;
    logic             missed;

    modport master (
        output trig_in, p1_width, delay, p2_width,
        input  pulse_out, block_out, busy, done, missed
    );

    modport slave (
        input  trig_in, p1_width, delay, p2_width,
        output pulse_out, block_out, busy, done, missed
    );

endinterface

// File: rtl/pulse_pair_gen_trig_edge_det.sv
// Rising-edge detector for the trigger; PULSE_TRIG_SYNC_EN adds a 2-flop synchroniser.
module trig_edge_det
    import pulse_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic trig_in,
    output logic trig_edge
);

    logic trig_s;
    logic trig_d;
    logic trig_q;

`ifdef PULSE_TRIG_SYNC_EN
    logic [1:0] sync_d;
    logic [1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[0], trig_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign trig_s = sync_q[1];
`else
    assign trig_s = trig_in;
`endif

    always_comb begin
        trig_d = trig_s;
    end

    // history resets high so a level already high at release is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b1;
        end else begin
            trig_q <= trig_d;
        end
    end

    assign trig_edge = trig_s & ~trig_q;

endmodule

// File: rtl/pulse_pair_gen.sv
// Two-pulse sequencer with blanking hold-off; define PULSE_TRIG_SYNC_EN to synchronise trig_in.
module pulse_pair_gen
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W        = PULSE_CNT_W,
    parameter int unsigned BLANK_CYCLES = 120
) (
    input logic              clk,
    input logic              rst,
    pulse_pair_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] BLANK_LOAD =
        (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

    function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] x);
        return CNT_W'(dur_clamp(CLAMP_W'(x)) - CLAMP_W'(1));
    endfunction

    logic trig_edge;

    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] sh_dly_d, sh_dly_q;
    logic [CNT_W-1:0] sh_p2_d, sh_p2_q;
    logic             pulse_d, pulse_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             missed_d, missed_q;

    trig_edge_det u_edge (
        .clk       (clk),
        .rst       (rst),
        .trig_in   (bus.trig_in),
        .trig_edge (trig_edge)
    );

    // p1_width is consumed on the accepting edge itself, so it needs no shadow copy
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_dly_d = sh_dly_q;
        sh_p2_d  = sh_p2_q;

        unique case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    state_d  = P1;
                    cnt_d    = load_of(bus.p1_width);
                    sh_dly_d = bus.delay;
                    sh_p2_d  = bus.p2_width;
                end
            end
            P1: begin
                if (cnt_q == '0) begin
                    state_d = DLY;
                    cnt_d   = load_of(sh_dly_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DLY: begin
                if (cnt_q == '0) begin
                    state_d = P2;
                    cnt_d   = load_of(sh_p2_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            P2: begin
                if (cnt_q == '0) begin
                    if (BLANK_CYCLES == 0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = BLANK;
                        cnt_d   = BLANK_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        pulse_d  = (state_d == P1) || (state_d == P2);
        busy_d   = (state_d != IDLE);
        done_d   = (state_q != IDLE) && (state_d == IDLE);
        missed_d = trig_edge && (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_dly_q <= '0;
            sh_p2_q  <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_dly_q <= sh_dly_d;
            sh_p2_q  <= sh_p2_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            missed_q <= missed_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.block_out = busy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.missed    = missed_q;

endmodule

// File: tb/tb_pulse_pair_gen.sv
// Scoreboard bench for pulse_pair_gen: a per-cycle expected output vector is queued as stimulus is applied.
module tb_pulse_pair_gen;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned BLANK = 4;

    // expected vector bit order: pulse, block, busy, done, missed
    localparam logic [4:0] V_PULSE  = 5'b11100;
    localparam logic [4:0] V_GAP    = 5'b01100;
    localparam logic [4:0] V_DONE   = 5'b00010;
    localparam logic [4:0] V_MISSED = 5'b00001;

    logic clk = 1'b0;
    logic rst;

    pulse_pair_gen_if #(.CNT_W(CNT_W)) bus ();

    pulse_pair_gen #(
        .CNT_W        (CNT_W),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [4:0] sb[$];
    logic [4:0] model_q[$];
    bit         prev_trig = 1'b1;
    bit         sync1 = 1'b1;
    bit         sync2 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
        end
    endtask

    function automatic int unsigned clamp1(input logic [CNT_W-1:0] x);
        return (x == '0) ? 1 : int'(x);
    endfunction

    // Predicts the outputs seen after the next posedge, from the inputs now applied.
    task automatic model_step();
        bit         trig_m;
        bit         edge_m;
        logic [4:0] e;
`ifdef PULSE_TRIG_SYNC_EN
        trig_m = sync2;
        sync2  = sync1;
        sync1  = bus.trig_in;
`else
        trig_m = bus.trig_in;
`endif
        edge_m    = trig_m && !prev_trig;
        prev_trig = trig_m;
        if (rst) begin
            model_q.delete();
            prev_trig = 1'b1;
            sync1     = 1'b1;
            sync2     = 1'b1;
            e         = '0;
        end else begin
            if (edge_m) begin
                if (model_q.size() == 0) begin
                    for (int i = 0; i < clamp1(bus.p1_width); i++) model_q.push_back(V_PULSE);
                    for (int i = 0; i < clamp1(bus.delay); i++)    model_q.push_back(V_GAP);
                    for (int i = 0; i < clamp1(bus.p2_width); i++) model_q.push_back(V_PULSE);
                    for (int i = 0; i < int'(BLANK); i++)          model_q.push_back(V_GAP);
                    model_q.push_back(V_DONE);
                end else begin
                    model_q[0] = model_q[0] | V_MISSED;
                end
            end
            e = (model_q.size() != 0) ? model_q.pop_front() : 5'b00000;
        end
        sb.push_back(e);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            chk("outs", {27'd0, bus.pulse_out, bus.block_out, bus.busy, bus.done, bus.missed},
                {27'd0, sb.pop_front()});
        end
    end

    initial begin
        rst          = 1'b1;
        bus.trig_in  = 1'b0;
        bus.p1_width = 3;
        bus.delay    = 5;
        bus.p2_width = 6;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // basic sequence
        bus.trig_in = 1'b1;
        repeat (2) step();
        bus.trig_in = 1'b0;
        repeat (25) step();

        // zero durations clamp to one cycle
        bus.p1_width = 0;
        bus.delay    = 0;
        bus.p2_width = 0;
        bus.trig_in  = 1'b1;
        step();
        bus.trig_in = 1'b0;
        repeat (12) step();

        // p2_width changed during P1 only affects the following sequence
        bus.p1_width = 8;
        bus.delay    = 5;
        bus.p2_width = 6;
        bus.trig_in  = 1'b1;
        repeat (4) step();
        bus.p2_width = 100;
        bus.trig_in  = 1'b0;
        repeat (30) step();
        bus.trig_in = 1'b1;
        step();
        bus.trig_in = 1'b0;
        repeat (125) step();

        // retrigger during DLY
        bus.p1_width = 3;
        bus.delay    = 5;
        bus.p2_width = 6;
        bus.trig_in  = 1'b1;
        step();
        bus.trig_in = 1'b0;
        repeat (4) step();
        bus.trig_in = 1'b1;
        step();
        bus.trig_in = 1'b0;
        repeat (22) step();

        // edge on the cycle the FSM returns to IDLE
        bus.trig_in = 1'b1;
        step();
        bus.trig_in = 1'b0;
        repeat (17) step();
        bus.trig_in = 1'b1;
        repeat (4) step();
        bus.trig_in = 1'b0;
        repeat (25) step();

        // async reset during P2, trigger held high across release
        bus.trig_in = 1'b1;
        step();
        bus.trig_in = 1'b0;
        repeat (11) step();
        bus.trig_in = 1'b1;
        rst         = 1'b1;
        #1;
        chk("rst_pulse", {31'd0, bus.pulse_out}, 32'd0);
        chk("rst_block", {31'd0, bus.block_out}, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy},      32'd0);
        sb.delete();
        sb.push_back(5'b00000);
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        bus.trig_in = 1'b0;
        step();
        bus.trig_in = 1'b1;
        step();
        bus.trig_in = 1'b0;
        repeat (25) step();

        repeat (2) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
